// File: rtl/peripheral_biu_pkg.sv
// rtl/peripheral_biu_pkg.sv - BIU transfer size/burst encodings and burst helper functions
package peripheral_biu_pkg;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HWORD = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    localparam logic [2:0] TYPE_SINGLE = 3'd0;
    localparam logic [2:0] TYPE_INCR   = 3'd1;
    localparam logic [2:0] TYPE_WRAP4  = 3'd2;
    localparam logic [2:0] TYPE_INCR4  = 3'd3;
    localparam logic [2:0] TYPE_WRAP8  = 3'd4;
    localparam logic [2:0] TYPE_INCR8  = 3'd5;
    localparam logic [2:0] TYPE_WRAP16 = 3'd6;
    localparam logic [2:0] TYPE_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_ERR
    } biu_resp_state_t;

    typedef struct packed {
        logic [2:0] size;
        logic [2:0] btype;
        logic       we;
        logic       lock;
        logic [2:0] prot;
    } biu_req_t;

    // Undefined-length INCR is serviced as a single beat.
    function automatic logic [4:0] burst_beats(input logic [2:0] btype);
        case (btype)
            TYPE_WRAP4,  TYPE_INCR4:  return 5'd4;
            TYPE_WRAP8,  TYPE_INCR8:  return 5'd8;
            TYPE_WRAP16, TYPE_INCR16: return 5'd16;
            default:                  return 5'd1;
        endcase
    endfunction

    function automatic logic is_wrap(input logic [2:0] btype);
        return (btype == TYPE_WRAP4) || (btype == TYPE_WRAP8) || (btype == TYPE_WRAP16);
    endfunction

    function automatic logic [15:0] wrap_mask(input logic [2:0] btype, input logic [2:0] size);
        return is_wrap(btype) ? ((16'(burst_beats(btype)) << size) - 16'd1) : 16'd0;
    endfunction

endpackage

// File: rtl/pu_riscv_biu_burst_adr.sv
// rtl/pu_riscv_biu_burst_adr.sv - next beat address and last-beat flag for BIU bursts
module pu_riscv_biu_burst_adr
    import peripheral_biu_pkg::*;
#(
    parameter int PLEN = 64
) (
    input  logic [PLEN-1:0] adr,
    input  logic [2:0]      size,
    input  logic [2:0]      btype,
    input  logic [4:0]      beats_left,
    output logic [PLEN-1:0] next_adr,
    output logic            last
);

    logic [PLEN-1:0] incr;
    logic [PLEN-1:0] mask;

    // Wrapping bursts keep the upper bits and wrap the low bits inside the burst span.
    always_comb begin
        incr     = adr + (PLEN'(1) << size);
        mask     = PLEN'(wrap_mask(btype, size));
        next_adr = is_wrap(btype) ? ((adr & ~mask) | (incr & mask)) : incr;
    end

    assign last = (beats_left == 5'd1);

endmodule

// File: rtl/pu_riscv_biu_mem_resp.sv
// rtl/pu_riscv_biu_mem_resp.sv - BIU memory target with single/burst access to an internal RAM
module pu_riscv_biu_mem_resp
    import peripheral_biu_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              PLEN      = 64,
    parameter int              MEM_WORDS = 1024,
    parameter logic [PLEN-1:0] BASE_ADR  = '0,
    parameter int              LATENCY   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    output logic            biu_d_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic            biu_lock_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o
);

    localparam int              NB        = XLEN / 8;
    localparam int              LANE_BITS = $clog2(NB);
    localparam int              AW        = $clog2(MEM_WORDS);
    localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_WORDS) << LANE_BITS;
    localparam logic [3:0]      LAT_LAST  = 4'(LATENCY - 1);

    biu_resp_state_t state, state_nxt;
    biu_req_t        req_q;
    logic [PLEN-1:0] cur_adr, next_adr, rd_adr;
    logic [4:0]      beats_left;
    logic [3:0]      lat_cnt;
    logic            last_beat, req_err, beat_err, beat_ok;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [XLEN-1:0] rd_q;
    logic            unused_attr;

    function automatic logic in_range(input logic [PLEN-1:0] a);
        return (a >= BASE_ADR) && ((a - BASE_ADR) < MEM_BYTES);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [PLEN-1:0] a);
        return AW'((a - BASE_ADR) >> LANE_BITS);
    endfunction

    pu_riscv_biu_burst_adr #(.PLEN(PLEN)) u_burst_adr (
        .adr        (cur_adr),
        .size       (req_q.size),
        .btype      (req_q.btype),
        .beats_left (beats_left),
        .next_adr   (next_adr),
        .last       (last_beat)
    );

    always_comb begin
        req_err = 1'b0;
        if (int'(biu_size_i) > LANE_BITS)
            req_err = 1'b1;
        else if ((biu_adri_i & ((PLEN'(1) << biu_size_i) - PLEN'(1))) != '0)
            req_err = 1'b1;
        else if (!in_range(biu_adri_i))
            req_err = 1'b1;
    end

    assign beat_err    = (state == ST_XFER) && !in_range(cur_adr);
    assign beat_ok     = (state == ST_XFER) && !beat_err;
    assign unused_attr = ^{req_q.lock, req_q.prot};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (biu_stb_i)
                         state_nxt = req_err ? ST_ERR : ((LATENCY > 0) ? ST_WAIT : ST_XFER);
            ST_WAIT: if (lat_cnt == LAT_LAST) state_nxt = ST_XFER;
            ST_XFER: if (beat_err || last_beat) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        biu_stb_ack_o = 1'b0;
        biu_ack_o     = 1'b0;
        biu_d_ack_o   = 1'b0;
        biu_err_o     = 1'b0;
        biu_adro_o    = '0;
        biu_q_o       = '0;
        case (state)
            ST_IDLE: biu_stb_ack_o = biu_stb_i && !rst_i;
            ST_XFER: begin
                biu_adro_o  = cur_adr;
                biu_err_o   = beat_err;
                biu_ack_o   = beat_ok;
                biu_d_ack_o = beat_ok && req_q.we;
                if (beat_ok && !req_q.we) biu_q_o = rd_q;
            end
            ST_ERR:  biu_err_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_adr    <= '0;
            req_q      <= '0;
            beats_left <= '0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (biu_stb_i) begin
                    cur_adr    <= biu_adri_i;
                    req_q      <= '{size: biu_size_i, btype: biu_type_i, we: biu_we_i,
                                    lock: biu_lock_i, prot: biu_prot_i};
                    beats_left <= burst_beats(biu_type_i);
                    lat_cnt    <= '0;
                end
                ST_WAIT: lat_cnt <= lat_cnt + 4'd1;
                ST_XFER: begin
                    cur_adr    <= next_adr;
                    beats_left <= beats_left - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++)
            be[b] = (b >= int'(cur_adr[LANE_BITS-1:0])) &&
                    (b <  int'(cur_adr[LANE_BITS-1:0]) + (1 << req_q.size));
    end

    // The read port looks one beat ahead so registered data lines up with each ack.
    always_comb begin
        case (state)
            ST_IDLE: rd_adr = biu_adri_i;
            ST_XFER: rd_adr = next_adr;
            default: rd_adr = cur_adr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (beat_ok && req_q.we) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[word_idx(cur_adr)][8*b +: 8] <= biu_d_i[8*b +: 8];
        end
        rd_q <= mem[word_idx(rd_adr)];
    end

endmodule

// File: tb/tb_pu_riscv_biu_mem_resp.sv
// tb/tb_pu_riscv_biu_mem_resp.sv - directed self-checking bench for pu_riscv_biu_mem_resp
module tb_pu_riscv_biu_mem_resp;
    import peripheral_biu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, stb_ack, d_ack, lock, we, ack, err;
    logic [63:0] adri, adro, d, q;
    logic [2:0]  size, btype, prot;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pu_riscv_biu_mem_resp dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .biu_stb_i     (stb),
        .biu_stb_ack_o (stb_ack),
        .biu_d_ack_o   (d_ack),
        .biu_adri_i    (adri),
        .biu_adro_o    (adro),
        .biu_size_i    (size),
        .biu_type_i    (btype),
        .biu_lock_i    (lock),
        .biu_prot_i    (prot),
        .biu_we_i      (we),
        .biu_d_i       (d),
        .biu_q_o       (q),
        .biu_ack_o     (ack),
        .biu_err_o     (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [63:0] a, input logic [2:0] sz, input logic [2:0] ty, input logic w);
        @(negedge clk);
        stb = 1'b1; adri = a; size = sz; btype = ty; we = w;
        #1 chk("stb_ack", stb_ack, 1);
        @(negedge clk);
        stb = 1'b0;
        #1 chk("wait_no_ack", ack, 0);
    endtask

    task automatic err_req(input logic [63:0] a, input logic [2:0] sz);
        @(negedge clk);
        stb = 1'b1; adri = a; size = sz; btype = TYPE_SINGLE; we = 1'b1; d = '1;
        #1 chk("err_stb_ack", stb_ack, 1);
        @(negedge clk);
        stb = 1'b0;
        #1;
        chk("err_pulse", err, 1);
        chk("err_no_ack", ack, 0);
        @(negedge clk);
        #1;
        chk("err_single", err, 0);
        chk("err_after_no_ack", ack, 0);
    endtask

    task automatic beat(input logic [63:0] exp_adr, input logic [63:0] wd,
                        input logic chkq, input logic [63:0] exp_q);
        @(negedge clk);
        d = wd;
        #1;
        chk("beat_ack", ack, 1);
        chk("beat_adr", adro, exp_adr);
        if (we) chk("beat_d_ack", d_ack, 1);
        else if (chkq) chk("beat_q", q, exp_q);
    endtask

    task automatic idle_chk();
        @(negedge clk);
        #1 chk("idle_no_ack", ack, 0);
    endtask

    function automatic logic [31:0] w8(input int j);
        return 32'h3000_0000 + 32'(j);
    endfunction

    initial begin
        rst = 1'b1; stb = 1'b1; adri = '0; size = '0; btype = '0;
        lock = 1'b0; prot = '0; we = 1'b0; d = '0;
        @(negedge clk);
        #1;
        chk("rst_stb_ack", stb_ack, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_adro", adro, 0);
        chk("rst_q", q, 0);
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        req(64'h0, SIZE_DWORD, TYPE_SINGLE, 1);
        beat(64'h0, 64'h0123_4567_89AB_CDEF, 0, 0);

        req(64'h40, SIZE_DWORD, TYPE_SINGLE, 1);
        beat(64'h40, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
        req(64'h40, SIZE_DWORD, TYPE_SINGLE, 0);
        beat(64'h40, 0, 1, 64'hDEAD_BEEF_CAFE_F00D);
        idle_chk();

        req(64'h40, SIZE_DWORD, TYPE_SINGLE, 1);
        beat(64'h40, 64'h0, 0, 0);
        req(64'h43, SIZE_BYTE, TYPE_SINGLE, 1);
        beat(64'h43, 64'h5555_5555_AB55_5555, 0, 0);
        req(64'h40, SIZE_DWORD, TYPE_SINGLE, 0);
        beat(64'h40, 0, 1, 64'h0000_0000_AB00_0000);

        req(64'h40, SIZE_DWORD, TYPE_INCR4, 1);
        for (int i = 0; i < 4; i++)
            beat(64'h40 + 64'(8 * i), 64'hA0A0_0000_0000_0000 | 64'(i), 0, 0);
        req(64'h58, SIZE_DWORD, TYPE_WRAP4, 0);
        beat(64'h58, 0, 1, 64'hA0A0_0000_0000_0003);
        beat(64'h40, 0, 1, 64'hA0A0_0000_0000_0000);
        beat(64'h48, 0, 1, 64'hA0A0_0000_0000_0001);
        beat(64'h50, 0, 1, 64'hA0A0_0000_0000_0002);
        idle_chk();

        req(64'h100, SIZE_WORD, TYPE_INCR8, 1);
        for (int i = 0; i < 8; i++)
            beat(64'h100 + 64'(4 * i), {w8(i), w8(i)}, 0, 0);
        req(64'h100, SIZE_WORD, TYPE_INCR8, 0);
        for (int i = 0; i < 8; i++)
            beat(64'h100 + 64'(4 * i), 0, 1, {w8(i | 1), w8(i & ~1)});
        idle_chk();

        err_req(64'h42, SIZE_WORD);
        err_req(64'h2000, SIZE_DWORD);
        req(64'h40, SIZE_DWORD, TYPE_SINGLE, 0);
        beat(64'h40, 0, 1, 64'hA0A0_0000_0000_0000);
        req(64'h0, SIZE_DWORD, TYPE_SINGLE, 0);
        beat(64'h0, 0, 1, 64'h0123_4567_89AB_CDEF);

        req(64'h1FF0, SIZE_DWORD, TYPE_INCR4, 0);
        beat(64'h1FF0, 0, 0, 0);
        beat(64'h1FF8, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("edge_err", err, 1);
        chk("edge_no_ack", ack, 0);
        chk("edge_adr", adro, 64'h2000);
        idle_chk();
        chk("edge_err_end", err, 0);

        req(64'h200, SIZE_DWORD, TYPE_INCR4, 1);
        for (int i = 0; i < 4; i++)
            beat(64'h200 + 64'(8 * i), 64'h0, 0, 0);
        req(64'h200, SIZE_DWORD, TYPE_INCR4, 1);
        beat(64'h200, 64'h1111_2222_3333_4444, 0, 0);
        @(negedge clk);
        d = 64'h5555_6666_7777_8888;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_d_ack", d_ack, 0);
        chk("mid_rst_adro", adro, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        req(64'h200, SIZE_DWORD, TYPE_INCR4, 0);
        beat(64'h200, 0, 1, 64'h1111_2222_3333_4444);
        beat(64'h208, 0, 0, 0);
        beat(64'h210, 0, 1, 64'h0);
        beat(64'h218, 0, 1, 64'h0);
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
